// File: rtl/noc_rd_port_arbiter.sv
// Shares one NMU AXI4 read port among N_REQ read DMAs: round-robin AR arbitration,
// an order FIFO of granted bursts, and R-beat steering back to the owning requester.
module noc_rd_port_arbiter #(
  parameter int N_REQ           = 3,
  parameter int AXI_ADDR_WIDTH  = 64,
  parameter int AXI_DATA_WIDTH  = 128,
  parameter int AXI_ID_WIDTH    = 16,
  parameter int MAX_OUTSTANDING = 4,
  parameter int M_ARID          = 0
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [N_REQ-1:0]                   s_arvalid,
  output logic [N_REQ-1:0]                   s_arready,
  input  logic [N_REQ*AXI_ADDR_WIDTH-1:0]    s_araddr,
  input  logic [N_REQ*8-1:0]                 s_arlen,
  input  logic [N_REQ*AXI_ID_WIDTH-1:0]      s_arid,
  output logic [N_REQ-1:0]                   s_rvalid,
  input  logic [N_REQ-1:0]                   s_rready,
  output logic [AXI_DATA_WIDTH-1:0]          s_rdata,
  output logic [1:0]                         s_rresp,
  output logic                               s_rlast,
  output logic [AXI_ID_WIDTH-1:0]            s_rid,
  output logic [AXI_ID_WIDTH-1:0]            m_arid,
  output logic [AXI_ADDR_WIDTH-1:0]          m_araddr,
  output logic [7:0]                         m_arlen,
  output logic [2:0]                         m_arsize,
  output logic [1:0]                         m_arburst,
  output logic                               m_arvalid,
  input  logic                               m_arready,
  input  logic [AXI_DATA_WIDTH-1:0]          m_rdata,
  input  logic [1:0]                         m_rresp,
  input  logic                               m_rlast,
  input  logic                               m_rvalid,
  output logic                               m_rready,
  output logic [$clog2(MAX_OUTSTANDING):0]   outstanding,
  output logic [N_REQ-1:0]                   rd_error,
  output logic                               busy
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CNT_W = $clog2(MAX_OUTSTANDING) + 1;
  localparam logic [CNT_W-1:0] MAX_OUT_C = CNT_W'(MAX_OUTSTANDING);
  localparam logic [2:0]       AR_SIZE   = 3'($clog2(AXI_DATA_WIDTH / 8));

  logic [IDX_W-1:0]          rr_ptr;
  logic [IDX_W-1:0]          grant_idx;
  logic                      grant_found;
  logic                      grant_en;
  logic [IDX_W-1:0]          next_rr;
  logic [AXI_ADDR_WIDTH-1:0] sel_addr;
  logic [7:0]                sel_len;
  logic [AXI_ID_WIDTH-1:0]   sel_id;

  logic [IDX_W-1:0]          fifo_idx [MAX_OUTSTANDING];
  logic [AXI_ID_WIDTH-1:0]   fifo_id  [MAX_OUTSTANDING];
  logic [PTR_W-1:0]          wr_ptr;
  logic [PTR_W-1:0]          rd_ptr;
  logic                      fifo_empty;
  logic [IDX_W-1:0]          head_idx;
  logic [N_REQ-1:0]          head_onehot;
  logic                      head_rready;
  logic                      beat_acc;
  logic                      pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Cyclic search for the first requesting index at or after rr_ptr.
  always_comb begin
    int cand;
    logic [IDX_W-1:0] cand_idx;
    cand        = 0;
    cand_idx    = '0;
    grant_idx   = '0;
    grant_found = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = int'(rr_ptr) + k;
      if (cand >= N_REQ) cand = cand - N_REQ;
      cand_idx = IDX_W'(cand);
      if (!grant_found && s_arvalid[cand_idx]) begin
        grant_found = 1'b1;
        grant_idx   = cand_idx;
      end
    end
  end

  assign grant_en = (!m_arvalid || m_arready) && (outstanding < MAX_OUT_C) && grant_found;
  assign next_rr  = (grant_idx == IDX_W'(N_REQ - 1)) ? '0 : grant_idx + IDX_W'(1);

  always_comb begin
    s_arready = '0;
    sel_addr  = '0;
    sel_len   = '0;
    sel_id    = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_idx == IDX_W'(i)) begin
        s_arready[i] = grant_en;
        sel_addr     = s_araddr[i*AXI_ADDR_WIDTH +: AXI_ADDR_WIDTH];
        sel_len      = s_arlen[i*8 +: 8];
        sel_id       = s_arid[i*AXI_ID_WIDTH +: AXI_ID_WIDTH];
      end
    end
  end

  assign m_arid    = AXI_ID_WIDTH'(M_ARID);
  assign m_arsize  = AR_SIZE;
  assign m_arburst = 2'b01;

  // Order FIFO payload; validity is tracked by outstanding and the pointers.
  always_ff @(posedge clk) begin
    if (grant_en) begin
      fifo_idx[wr_ptr] <= grant_idx;
      fifo_id[wr_ptr]  <= sel_id;
    end
  end

  assign fifo_empty = (outstanding == '0);
  assign head_idx   = fifo_idx[rd_ptr];
  assign s_rid      = fifo_id[rd_ptr];

  always_comb begin
    head_onehot = '0;
    head_rready = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (head_idx == IDX_W'(i)) begin
        head_onehot[i] = 1'b1;
        head_rready    = s_rready[i];
      end
    end
  end

  assign s_rvalid = (m_rvalid && !fifo_empty) ? head_onehot : '0;
  assign m_rready = !fifo_empty && head_rready;
  assign s_rdata  = m_rdata;
  assign s_rresp  = m_rresp;
  assign s_rlast  = m_rlast;
  assign beat_acc = m_rvalid && m_rready;
  assign pop      = beat_acc && m_rlast;
  assign busy     = m_arvalid || !fifo_empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      m_arvalid   <= 1'b0;
      m_araddr    <= '0;
      m_arlen     <= '0;
      rr_ptr      <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      outstanding <= '0;
      rd_error    <= '0;
    end else begin
      if (grant_en) begin
        m_arvalid <= 1'b1;
        m_araddr  <= sel_addr;
        m_arlen   <= sel_len;
        rr_ptr    <= next_rr;
        wr_ptr    <= ptr_inc(wr_ptr);
      end else if (m_arready) begin
        m_arvalid <= 1'b0;
      end
      if (pop) rd_ptr <= ptr_inc(rd_ptr);
      case ({grant_en, pop})
        2'b10:   outstanding <= outstanding + CNT_W'(1);
        2'b01:   outstanding <= outstanding - CNT_W'(1);
        default: outstanding <= outstanding;
      endcase
      // SLVERR/DECERR both have resp[1] set; the beat itself is still forwarded.
      if (beat_acc && m_rresp[1]) rd_error <= rd_error | head_onehot;
    end
  end

endmodule

// File: doc/noc_rd_port_arbiter.md
Name: noc_rd_port_arbiter

Overview:
- Shares one NoC NMU AXI4 read port among N_REQ read-DMA engines (attention-output, weight and residual streams in the self-output layer).
- Arbitrates the AR channel round-robin and tracks issue order in an order FIFO.
- Steers R beats back to the requester that owns each burst.
- Sits between the read DMAs and the single XPM_NMU read master; error status is reported per requester.

Parameters:
N_REQ, 3, number of read requesters
AXI_ADDR_WIDTH, 64, address width
AXI_DATA_WIDTH, 128, read data width
AXI_ID_WIDTH, 16, ID width
MAX_OUTSTANDING, 4, order FIFO depth, i.e. maximum bursts in flight (power of 2)
M_ARID, 0, fixed ID driven on the master port; a single ID forces in-order return

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
s_arvalid  in  N_REQ  per-requester AR valid
s_arready  out  N_REQ  per-requester AR ready (one-hot grant)
s_araddr  in  N_REQ*AXI_ADDR_WIDTH  flattened addresses, requester i at slice i
s_arlen  in  N_REQ*8  flattened burst lengths
s_arid  in  N_REQ*AXI_ID_WIDTH  flattened requester IDs
s_rvalid  out  N_REQ  per-requester R valid
s_rready  in  N_REQ  per-requester R ready
s_rdata  out  AXI_DATA_WIDTH  R data, broadcast to all requesters
s_rresp  out  2  R response, broadcast
s_rlast  out  1  R last, broadcast
s_rid  out  AXI_ID_WIDTH  stored s_arid of the burst at the FIFO head
m_arid / m_araddr / m_arlen  out  AXI_ID_WIDTH / AXI_ADDR_WIDTH / 8  master AR fields
m_arsize  out  3  constant log2(AXI_DATA_WIDTH/8)
m_arburst  out  2  constant 2'b01 (INCR)
m_arvalid  out  1  master AR valid
m_arready  in  1  master AR ready
m_rdata / m_rresp / m_rlast / m_rvalid  in  data / 2 / 1 / 1  master R channel
m_rready  out  1  master R ready
outstanding  out  $clog2(MAX_OUTSTANDING)+1  bursts granted and not yet completed
rd_error  out  N_REQ  sticky per-requester error flag
busy  out  1  high when m_arvalid is asserted or outstanding != 0

Behaviour:
- Reset (rst high at a clk edge), registered outputs: m_arvalid=0, outstanding=0, rd_error=0, rr_ptr=0, order FIFO empty, m_araddr=0, m_arlen=0. Derived outputs therefore reset to: s_arready=0, s_rvalid=0, m_rready=0, busy=0.
- Reset mid-burst discards all in-flight tracking. The external fabric must be reset together with this block.
- Grant enable: grant_en = (!m_arvalid || m_arready) && (outstanding < MAX_OUTSTANDING) && (|s_arvalid).
- Grant selection: the first set s_arvalid bit at or after rr_ptr, searching cyclically.
- s_arready is combinational and one-hot on the granted index only when grant_en is high.
- On grant, at the clk edge:
  - Latch the granted requester's araddr/arlen into the m_ar* registers and set m_arvalid=1.
  - Push {index, s_arid} into the order FIFO.
  - Set rr_ptr = (granted+1) mod N_REQ.
- Grant-to-master latency: 1 cycle. Back-to-back grants are allowed: a grant may occur in the same cycle the master handshakes.
- m_arvalid clears on m_arready when no new grant occurs that cycle. m_ar* fields are stable while m_arvalid && !m_arready.
- When outstanding == MAX_OUTSTANDING, no grant is made. A pop in that same cycle does not enable a grant; the grant waits until the next cycle.
- R steering is combinational with FIFO head h:
  - s_rvalid[h] = m_rvalid && !fifo_empty; all other s_rvalid bits are 0.
  - m_rready = !fifo_empty && s_rready[h].
  - s_rdata/s_rresp/s_rlast pass through from the master; s_rid = stored ID at the head.
- If the FIFO is empty, m_rready=0 and beats stall.
- Pop on m_rvalid && m_rready && m_rlast.
- outstanding = push - pop per cycle. A simultaneous push and pop leaves it unchanged.
- Error: any accepted beat with m_rresp[1]=1 (SLVERR/DECERR) sets rd_error[h]. The flag clears only on rst. Data is still forwarded.
- No beat counting: bursts are delimited by m_rlast only.

Test Plan:
- Single requester: req1 issues addr 0x1000, len 3 → m_arvalid one cycle after s_arready[1]; m_araddr=0x1000, m_arlen=3, m_arsize=4, m_arburst=1. Four beats reach only s_rvalid[1]; outstanding goes 1→0 on the last beat.
- All three requesters assert continuously with m_arready=1 → grant order 0,1,2,0,1,2. The order FIFO fills, so grants stop at outstanding=4 and resume one cycle after a pop.
- m_arready held low 5 cycles → m_ar* fields stable and no further s_arready pulses. On release, the next grant lands in the same cycle as the handshake.
- Two bursts issued (req2 len 1, then req0 len 0); s_rready[2] low 3 cycles → m_rready low and no beat lost. Beats route to req2 then req0, with s_rid matching each burst's s_arid.
- Beat with m_rresp=2'b10 on req0's burst → rd_error=3'b001, and it stays set through the following clean bursts.
- rst asserted with 2 bursts outstanding → next cycle outstanding=0, m_arvalid=0, s_rvalid=0, rd_error=0, and the first post-reset grant goes to req0.
